// File: rtl/hls_seq_pkg.sv
// hls_seq_pkg: shared op codes, status codes, FSM states and default run timeout.
package hls_seq_pkg;
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_RUN_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_MEM_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_SPURIOUS_DONE = 2'd3;
  localparam int unsigned DEFAULT_TIMEOUT = 200000000;
  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_START,
    S_RUN,
    S_ABORT,
    S_RSP
  } state_t;
endpackage

// File: rtl/hls_seq_cycle_counter.sv
// hls_seq_cycle_counter: clear/enable cycle counter flagging when the next count hits limit.
module hls_seq_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] nxt,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= nxt;
  end
  assign nxt = cnt + W'(1);
  assign tc = nxt == limit;
endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: command/response sequencer that preloads, launches, times and reads back
// one Bambu accelerator through start/done and slave-RAM channel 0.
module hls_run_sequencer
  import hls_seq_pkg::*;
#(
  parameter int          ADDR_W  = 9,
  parameter int          DATA_W  = 64,
  parameter int          SIZE_W  = 7,
  parameter int          CYC_W   = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int          MEM_TO  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [SIZE_W-1:0]   cmd_size,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_status,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                start_port,
  input  logic                done_port,
  output logic                acc_abort,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [2*DATA_W-1:0] S_Wdata_ram,
  output logic [2*SIZE_W-1:0] S_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic                busy
);
  if (CYC_W < 32 && (TIMEOUT >> CYC_W) != 0) begin : g_timeout_check
    $error("TIMEOUT does not fit in CYC_W bits");
  end
  state_t state, nxt_state;
  logic [1:0] op_q, st_q, st_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, data_q, data_n;
  logic [SIZE_W-1:0] size_q;
  logic load_rsp, spur, clr_spur, ab, req, accept, tc, unused_in;
  logic [CYC_W-1:0] cnt_nxt;
  assign unused_in = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};
  // One counter serves both the run latency and the per-access memory timeout.
  hls_seq_cycle_counter #(.W(CYC_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr(state == S_START || state == S_MEM_REQ),
    .en(state == S_RUN || state == S_MEM_WAIT),
    .limit(state == S_MEM_WAIT ? CYC_W'(MEM_TO) : CYC_W'(TIMEOUT)),
    .nxt(cnt_nxt),
    .tc(tc)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      st_q <= '0;
      data_q <= '0;
      spur <= 1'b0;
      ab <= 1'b0;
    end else begin
      state <= nxt_state;
      if (accept) {op_q, addr_q, wdata_q, size_q} <= {cmd_op, cmd_addr, cmd_wdata, cmd_size};
      if (load_rsp) {st_q, data_q} <= {st_n, data_n};
      spur <= (spur & ~clr_spur) | (done_port & state != S_START & state != S_RUN);
      ab <= state == S_ABORT && !ab;
    end
  end
  always_comb begin
    nxt_state = state;
    load_rsp = 1'b0;
    st_n = ST_OK;
    data_n = '0;
    clr_spur = 1'b0;
    case (state)
      S_IDLE: if (cmd_valid) begin
        if (cmd_op == OP_NOP) begin
          nxt_state = S_RSP;
          load_rsp = 1'b1;
        end else if (cmd_op == OP_RUN) begin
          nxt_state = spur ? S_RSP : S_START;
          load_rsp = spur;
          st_n = ST_SPURIOUS_DONE;
          clr_spur = spur;
        end else nxt_state = S_MEM_REQ;
      end
      S_MEM_REQ: nxt_state = S_MEM_WAIT;
      S_MEM_WAIT: if (Sout_DataRdy[0]) begin
        nxt_state = S_RSP;
        load_rsp = 1'b1;
        data_n = op_q == OP_READ ? Sout_Rdata_ram[DATA_W-1:0] : '0;
      end else if (tc) begin
        nxt_state = S_RSP;
        load_rsp = 1'b1;
        st_n = ST_MEM_TIMEOUT;
      end
      S_START: nxt_state = S_RUN;
      S_RUN: if (done_port) begin
        nxt_state = S_RSP;
        load_rsp = 1'b1;
        data_n = DATA_W'(cnt_nxt);
      end else if (tc) nxt_state = S_ABORT;
      S_ABORT: if (ab) begin
        nxt_state = S_RSP;
        load_rsp = 1'b1;
        st_n = ST_RUN_TIMEOUT;
        data_n = DATA_W'(TIMEOUT);
      end
      S_RSP: if (rsp_ready) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end
  assign cmd_ready = state == S_IDLE;
  assign busy = !cmd_ready;
  assign accept = cmd_valid && cmd_ready;
  assign start_port = state == S_START;
  assign acc_abort = state == S_ABORT;
  assign rsp_valid = state == S_RSP;
  assign rsp_status = st_q;
  assign rsp_data = data_q;
  assign req = state == S_MEM_REQ;
  assign S_oe_ram = {1'b0, req && op_q == OP_READ};
  assign S_we_ram = {1'b0, req && op_q == OP_WRITE};
  assign S_addr_ram = {{ADDR_W{1'b0}}, req ? addr_q : '0};
  assign S_Wdata_ram = {{DATA_W{1'b0}}, req ? wdata_q : '0};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, req ? size_q : '0};
endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed scoreboard bench for hls_run_sequencer with a short run timeout.
module tb_hls_run_sequencer;
  import hls_seq_pkg::*;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int SW = 7;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, start_port, done_port, acc_abort, busy;
  logic [1:0] cmd_op, rsp_status, S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, rsp_data;
  logic [SW-1:0] cmd_size;
  logic [2*AW-1:0] S_addr_ram;
  logic [2*DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [2*SW-1:0] S_data_ram_size;
  int checks = 0;
  int failures = 0;
  longint cyc = 0;
  longint acc_cyc, rsp_cyc;
  int start_n, abort_n, we_n, oe_n;
  int rdy_delay = 1;
  logic [DW-1:0] rd_val = '0;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_wdata;
  logic [SW-1:0] seen_size;
  logic [65:0] exp_q[$];
  logic [65:0] e_mon;

  hls_run_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CYC_W(32), .TIMEOUT(100), .MEM_TO(16)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .start_port(start_port), .done_port(done_port), .acc_abort(acc_abort),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and pops the scoreboard on every accepted response.
  always @(negedge clock) begin
    start_n += int'(start_port);
    abort_n += int'(acc_abort);
    we_n += int'(S_we_ram[0]);
    oe_n += int'(S_oe_ram[0]);
    if (rsp_valid && rsp_ready) begin
      rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got status %0d data %0h, none expected", rsp_status, rsp_data);
      end else begin
        e_mon = exp_q.pop_front();
        chk("rsp_status", 64'(rsp_status), 64'(e_mon[65:64]));
        chk("rsp_data", rsp_data, e_mon[63:0]);
      end
    end
  end

  // Slave RAM model: DataRdy rdy_delay cycles after the request, none when rdy_delay is 0.
  initial begin
    Sout_DataRdy = '0;
    Sout_Rdata_ram = '0;
    forever begin
      @(negedge clock);
      if (S_oe_ram[0] || S_we_ram[0]) begin
        seen_addr = S_addr_ram[AW-1:0];
        seen_wdata = S_Wdata_ram[DW-1:0];
        seen_size = S_data_ram_size[SW-1:0];
        if (rdy_delay > 0) begin
          repeat (rdy_delay) @(posedge clock);
          #1;
          Sout_DataRdy = 2'b01;
          Sout_Rdata_ram = {64'hDEADBEEFDEADBEEF, rd_val};
          @(posedge clock);
          #1;
          Sout_DataRdy = '0;
          Sout_Rdata_ram = '0;
        end
      end
    end
  end

  task automatic wait_idle(string name);
    int n = 0;
    while (!cmd_ready && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL %s: cmd_ready still low after 500 cycles", name);
    end
  endtask

  task automatic send(logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s,
                      bit exp_rsp, logic [1:0] est, logic [DW-1:0] edata);
    wait_idle("send");
    if (exp_rsp) exp_q.push_back({est, edata});
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = d;
    cmd_size = s;
    acc_cyc = cyc;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic clr_counts();
    start_n = 0;
    abort_n = 0;
    we_n = 0;
    oe_n = 0;
  endtask

  task automatic pulse_done(int after);
    repeat (after) @(posedge clock);
    #1;
    done_port = 1'b1;
    @(posedge clock);
    #1;
    done_port = 1'b0;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_status"}, 64'(rsp_status), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_start_abort"}, 64'({start_port, acc_abort}), 0);
    chk({tag, "_oe_we"}, 64'({S_oe_ram, S_we_ram}), 0);
    chk({tag, "_addr"}, 64'(S_addr_ram), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_size = '0;
    done_port = 1'b0;
    rsp_ready = 1'b1;
    clr_counts();
    repeat (3) @(posedge clock);
    #1;
    reset_checks("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    // WRITE, DataRdy one cycle after the request
    clr_counts();
    rdy_delay = 1;
    send(OP_WRITE, 9'd5, 64'hA5, 7'd8, 1'b1, ST_OK, 64'd0);
    wait_idle("t1");
    chk("t1_we_pulses", 64'(we_n), 1);
    chk("t1_oe_pulses", 64'(oe_n), 0);
    chk("t1_addr", 64'(seen_addr), 5);
    chk("t1_wdata", seen_wdata, 64'hA5);
    chk("t1_size", 64'(seen_size), 8);
    chk("t1_latency", 64'(rsp_cyc - acc_cyc), 3);
    // READ, DataRdy two cycles later
    clr_counts();
    rdy_delay = 2;
    rd_val = 64'hA5;
    send(OP_READ, 9'd5, 64'd0, 7'd8, 1'b1, ST_OK, 64'hA5);
    wait_idle("t2");
    chk("t2_oe_cycles", 64'(oe_n), 1);
    chk("t2_we_pulses", 64'(we_n), 0);
    chk("t2_latency", 64'(rsp_cyc - acc_cyc), 4);
    // READ with no DataRdy: memory timeout after 16 wait cycles
    rdy_delay = 0;
    send(OP_READ, 9'd7, 64'd0, 7'd64, 1'b1, ST_MEM_TIMEOUT, 64'd0);
    wait_idle("memto");
    chk("memto_latency", 64'(rsp_cyc - acc_cyc), 18);
    // NOP
    send(OP_NOP, 9'd0, 64'd0, 7'd0, 1'b1, ST_OK, 64'd0);
    wait_idle("nop");
    chk("nop_latency", 64'(rsp_cyc - acc_cyc), 1);
    // RUN, done 40 cycles after start
    clr_counts();
    send(OP_RUN, 9'd0, 64'd0, 7'd0, 1'b1, ST_OK, 64'd40);
    pulse_done(40);
    wait_idle("t3");
    chk("t3_start_pulses", 64'(start_n), 1);
    chk("t3_abort", 64'(abort_n), 0);
    chk("t3_latency", 64'(rsp_cyc - acc_cyc), 42);
    // RUN, no done: timeout at 100
    clr_counts();
    send(OP_RUN, 9'd0, 64'd0, 7'd0, 1'b1, ST_RUN_TIMEOUT, 64'd100);
    wait_idle("t4a");
    chk("t4a_abort_cycles", 64'(abort_n), 2);
    chk("t4a_start_pulses", 64'(start_n), 1);
    chk("t4a_latency", 64'(rsp_cyc - acc_cyc), 104);
    // RUN, done on the timeout cycle: done wins
    clr_counts();
    send(OP_RUN, 9'd0, 64'd0, 7'd0, 1'b1, ST_OK, 64'd100);
    pulse_done(100);
    wait_idle("t4b");
    chk("t4b_abort", 64'(abort_n), 0);
    // done while idle, then RUN reports spurious done without a start pulse
    clr_counts();
    pulse_done(0);
    send(OP_RUN, 9'd0, 64'd0, 7'd0, 1'b1, ST_SPURIOUS_DONE, 64'd0);
    wait_idle("t5a");
    chk("t5a_start_pulses", 64'(start_n), 0);
    clr_counts();
    send(OP_RUN, 9'd0, 64'd0, 7'd0, 1'b1, ST_OK, 64'd10);
    pulse_done(10);
    wait_idle("t5b");
    chk("t5b_start_pulses", 64'(start_n), 1);
    // response held while rsp_ready is low
    rsp_ready = 1'b0;
    rdy_delay = 1;
    rd_val = 64'h1234;
    send(OP_READ, 9'd9, 64'd0, 7'd16, 1'b1, ST_OK, 64'h1234);
    for (int n = 0; n < 50 && !rsp_valid; n++) begin
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 64'(rsp_valid), 1);
      chk("hold_status", 64'(rsp_status), 0);
      chk("hold_data", rsp_data, 64'h1234);
      @(posedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    wait_idle("hold");
    // reset during RUN abandons it with no response
    send(OP_RUN, 9'd0, 64'd0, 7'd0, 1'b0, ST_OK, 64'd0);
    repeat (20) @(posedge clock);
    #1;
    chk("midrun_busy", 64'(busy), 1);
    reset = 1'b1;
    #2;
    reset_checks("midrun_reset");
    @(posedge clock);
    #1;
    reset = 1'b0;
    send(OP_NOP, 9'd0, 64'd0, 7'd0, 1'b1, ST_OK, 64'd0);
    wait_idle("post_reset");
    repeat (5) @(posedge clock);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
